boot_run_ctrl: RTL and testbench



---
 rtl/boot_run_pkg.sv | 22 ++
 rtl/boot_run_ctrl_load_port.sv | 60 ++++++
 rtl/boot_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_boot_run_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_run_pkg.sv
// Shared state encoding and default widths for the boot/run sequencer.
package boot_run_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_PROG,
        ST_LOAD_DATA,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_ERROR
    } state_e;

    // States in which a BOOT request is honoured and the sequencer is not busy.
    function automatic logic is_rest(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/boot_run_ctrl_load_port.sv
// Registered memory-load writer: turns accepted stream beats into WE/ADDR/DATA
// one cycle later, counts words and flags a beat that would run past the top address.
module load_port
    import boot_run_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              beat_i,
    input  logic              last_i,
    input  logic [31:0]       data_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o,
    output logic [ADDR_W:0]   words_o,
    output logic              ovf_o
);

    localparam logic [ADDR_W:0] TOP_IDX = {1'b0, {ADDR_W{1'b1}}};

    logic [ADDR_W:0]   idx_q, idx_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (beat_i) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            idx_q <= idx_d;
            we_q  <= beat_i;
            if (beat_i) begin
                addr_q <= idx_q[ADDR_W-1:0];
                data_q <= data_i;
            end
        end
    end

    // The top-address word is still written; the controller stops accepting after it.
    assign ovf_o   = beat_i && !last_i && (idx_q == TOP_IDX);
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign words_o = idx_q;

endmodule

// File: rtl/boot_run_ctrl.sv
// Boot/run sequencer: loads program and data memories from one word stream,
// releases the core, and counts run cycles until CORE_OK. Optional macro: RUN_WATCHDOG_EN.
module boot_run_ctrl
    import boot_run_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RST_HOLD = 4,
    parameter int WDOG_MAX = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BOOT,
    input  logic              S_VALID,
    output logic              S_READY,
    input  logic [31:0]       S_DATA,
    input  logic              S_LAST,
    output logic              PROG_WE,
    output logic [ADDR_W-1:0] PROG_ADDR,
    output logic [31:0]       PROG_DATA,
    output logic              DATA_WE,
    output logic [ADDR_W-1:0] DATA_ADDR,
    output logic [31:0]       DATA_DATA,
    output logic              CORE_RSTn,
    output logic              CORE_EN,
    output logic              CORE_START,
    input  logic              CORE_OK,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [CNT_W-1:0]  CYCLES,
    output logic [ADDR_W:0]   PROG_WORDS,
    output logic [ADDR_W:0]   DATA_WORDS
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  WDOG_LIM  = CNT_W'(WDOG_MAX);
`ifdef RUN_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d, cycles_inc;
    logic               boot_go, prog_beat, data_beat, prog_ovf, data_ovf, wd_hit;

    assign boot_go    = BOOT && is_rest(state_q);
    assign prog_beat  = S_VALID && (state_q == ST_LOAD_PROG);
    assign data_beat  = S_VALID && (state_q == ST_LOAD_DATA);
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
    // The cycle that brings the count up to the limit is the last one allowed.
    assign wd_hit     = WDOG_ON && (cycles_inc == WDOG_LIM);

    load_port #(.ADDR_W(ADDR_W)) u_prog (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (boot_go),
        .beat_i  (prog_beat),
        .last_i  (S_LAST),
        .data_i  (S_DATA),
        .we_o    (PROG_WE),
        .addr_o  (PROG_ADDR),
        .data_o  (PROG_DATA),
        .words_o (PROG_WORDS),
        .ovf_o   (prog_ovf)
    );

    load_port #(.ADDR_W(ADDR_W)) u_data (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (boot_go),
        .beat_i  (data_beat),
        .last_i  (S_LAST),
        .data_i  (S_DATA),
        .we_o    (DATA_WE),
        .addr_o  (DATA_ADDR),
        .data_o  (DATA_DATA),
        .words_o (DATA_WORDS),
        .ovf_o   (data_ovf)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (BOOT) state_d = ST_LOAD_PROG;
            end
            ST_LOAD_PROG: begin
                if (prog_ovf)                 state_d = ST_ERROR;
                else if (prog_beat && S_LAST) state_d = ST_LOAD_DATA;
            end
            ST_LOAD_DATA: begin
                if (data_ovf)                 state_d = ST_ERROR;
                else if (data_beat && S_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (hold_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (CORE_OK)     state_d = ST_DONE;
                else if (wd_hit) state_d = ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase

        hold_d = (state_q == ST_RELEASE) ? hold_q + 1'b1 : '0;

        cycles_d = cycles_q;
        if (boot_go) begin
            cycles_d = '0;
        end else if (state_q == ST_RUN) begin
            cycles_d = cycles_inc;
        end
    end

    always_comb begin
        S_READY    = 1'b0;
        CORE_RSTn  = 1'b0;
        CORE_EN    = 1'b0;
        CORE_START = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        BUSY       = !is_rest(state_q);
        case (state_q)
            ST_LOAD_PROG, ST_LOAD_DATA: S_READY = 1'b1;
            ST_RUN: begin
                CORE_RSTn  = 1'b1;
                CORE_EN    = 1'b1;
                CORE_START = 1'b1;
            end
            ST_DONE: begin
                CORE_RSTn = 1'b1;
                DONE      = 1'b1;
            end
            ST_ERROR: ERR = 1'b1;
            default: ;
        endcase
    end

    assign CYCLES = cycles_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Directed bench for boot_run_ctrl with a write scoreboard for the load ports.
module tb_boot_run_ctrl;

    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 32;
    localparam int RST_HOLD = 4;
    localparam int WDOG_MAX = 50;

    logic              CLK = 1'b0;
    logic              RST, BOOT, S_VALID, S_READY, S_LAST;
    logic [31:0]       S_DATA;
    logic              PROG_WE, DATA_WE;
    logic [ADDR_W-1:0] PROG_ADDR, DATA_ADDR;
    logic [31:0]       PROG_DATA, DATA_DATA;
    logic              CORE_RSTn, CORE_EN, CORE_START, CORE_OK;
    logic              BUSY, DONE, ERR;
    logic [CNT_W-1:0]  CYCLES;
    logic [ADDR_W:0]   PROG_WORDS, DATA_WORDS;

    always #5 CLK = ~CLK;

    boot_run_ctrl #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .WDOG_MAX(WDOG_MAX)
    ) dut (
        .CLK(CLK), .RST(RST), .BOOT(BOOT),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_LAST(S_LAST),
        .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR), .PROG_DATA(PROG_DATA),
        .DATA_WE(DATA_WE), .DATA_ADDR(DATA_ADDR), .DATA_DATA(DATA_DATA),
        .CORE_RSTn(CORE_RSTn), .CORE_EN(CORE_EN), .CORE_START(CORE_START), .CORE_OK(CORE_OK),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CYCLES(CYCLES),
        .PROG_WORDS(PROG_WORDS), .DATA_WORDS(DATA_WORDS)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t prog_sb[$];
    wr_t data_sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  seg;   // 0: program segment, 1: data segment, 2: stream not accepted
    int  pidx, didx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One stream cycle: drive a word, predict its write, check it one cycle later.
    task automatic cyc(input logic v, input logic [31:0] d, input logic l);
        logic take;
        int   s;
        wr_t  e;
        S_VALID = v;
        S_DATA  = d;
        S_LAST  = l;
        s       = seg;
        take    = v && (s != 2);
        chk("S_READY", S_READY, s != 2);
        if (take) begin
            e.data = d;
            if (s == 0) begin
                e.addr = pidx[ADDR_W-1:0];
                prog_sb.push_back(e);
            end else begin
                e.addr = didx[ADDR_W-1:0];
                data_sb.push_back(e);
            end
        end
        tick();
        chk("PROG_WE", PROG_WE, take && (s == 0));
        chk("DATA_WE", DATA_WE, take && (s == 1));
        if (PROG_WE && prog_sb.size() > 0) begin
            e = prog_sb.pop_front();
            chk("PROG_ADDR", PROG_ADDR, e.addr);
            chk("PROG_DATA", PROG_DATA, e.data);
        end
        if (DATA_WE && data_sb.size() > 0) begin
            e = data_sb.pop_front();
            chk("DATA_ADDR", DATA_ADDR, e.addr);
            chk("DATA_DATA", DATA_DATA, e.data);
        end
        if (take) begin
            if (s == 0) begin
                pidx++;
                if (l) seg = 1;
                else if (pidx == 2**ADDR_W) seg = 2;
            end else begin
                didx++;
                if (l || didx == 2**ADDR_W) seg = 2;
            end
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
    endtask

    task automatic boot_req();
        BOOT = 1'b1;
        tick();
        BOOT = 1'b0;
        seg  = 0;
        pidx = 0;
        didx = 0;
        chk("BOOT_BUSY", BUSY, 1'b1);
        chk("BOOT_DONE", DONE, 1'b0);
        chk("BOOT_ERR", ERR, 1'b0);
        chk("BOOT_CYCLES", CYCLES, 0);
        chk("BOOT_PWORDS", PROG_WORDS, 0);
    endtask

    // Called in the cycle of the last data write; core reset must rise RST_HOLD cycles later.
    task automatic do_release();
        chk("REL_RSTn0", CORE_RSTn, 1'b0);
        for (int k = 1; k <= RST_HOLD; k++) begin
            tick();
            chk("REL_RSTn", CORE_RSTn, k == RST_HOLD);
            chk("REL_EN", CORE_EN, k == RST_HOLD);
            chk("REL_START", CORE_START, k == RST_HOLD);
        end
    endtask

    task automatic run(input int n, input logic ok_last);
        for (int i = 1; i <= n; i++) begin
            CORE_OK = ok_last && (i == n);
            tick();
        end
        CORE_OK = 1'b0;
    endtask

    initial begin
        RST = 1'b1; BOOT = 1'b0; S_VALID = 1'b0; S_LAST = 1'b0; S_DATA = '0; CORE_OK = 1'b0;
        seg = 2; pidx = 0; didx = 0;
        tick();
        tick();
        chk("RST_READY", S_READY, 1'b0);
        chk("RST_PWE", PROG_WE, 1'b0);
        chk("RST_RSTn", CORE_RSTn, 1'b0);
        chk("RST_EN", CORE_EN, 1'b0);
        chk("RST_BUSY", BUSY, 1'b0);
        chk("RST_DONE", DONE, 1'b0);
        chk("RST_ERR", ERR, 1'b0);
        chk("RST_CYCLES", CYCLES, 0);
        RST = 1'b0;
        tick();

        // 3 program + 2 data words, continuous valid, OK on the 10th run cycle
        boot_req();
        cyc(1'b1, 32'hA000_0000, 1'b0);
        cyc(1'b1, 32'hA000_0001, 1'b0);
        cyc(1'b1, 32'hA000_0002, 1'b1);
        cyc(1'b1, 32'hD000_0000, 1'b0);
        cyc(1'b1, 32'hD000_0001, 1'b1);
        chk("PROG_WORDS", PROG_WORDS, 3);
        chk("DATA_WORDS", DATA_WORDS, 2);
        do_release();
        chk("RUN_CYCLES0", CYCLES, 0);
        run(10, 1'b1);
        chk("DONE", DONE, 1'b1);
        chk("DONE_CYCLES", CYCLES, 10);
        chk("DONE_EN", CORE_EN, 1'b0);
        chk("DONE_START", CORE_START, 1'b0);
        chk("DONE_RSTn", CORE_RSTn, 1'b1);
        chk("DONE_BUSY", BUSY, 1'b0);
        cyc(1'b1, 32'h1234_5678, 1'b0);
        CORE_OK = 1'b1;
        tick();
        CORE_OK = 1'b0;
        chk("FROZEN_CYCLES", CYCLES, 10);
        chk("FROZEN_PWORDS", PROG_WORDS, 3);
        chk("FROZEN_DONE", DONE, 1'b1);

        // valid gaps during the program segment; OK on the first run cycle
        boot_req();
        cyc(1'b1, 32'hB000_0000, 1'b0);
        cyc(1'b0, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 32'hB000_0001, 1'b1);
        cyc(1'b0, 32'hDEAD_BEEF, 1'b1);
        cyc(1'b1, 32'hC000_0000, 1'b1);
        chk("GAP_PWORDS", PROG_WORDS, 2);
        chk("GAP_DWORDS", DATA_WORDS, 1);
        do_release();
        run(1, 1'b1);
        chk("GAP_DONE", DONE, 1'b1);
        chk("GAP_CYCLES", CYCLES, 1);

        // reset in the middle of the data segment, then a clean reload
        boot_req();
        cyc(1'b1, 32'hE000_0000, 1'b1);
        cyc(1'b1, 32'hE100_0000, 1'b0);
        RST = 1'b1; S_VALID = 1'b1; S_DATA = 32'hFFFF_FFFF;
        tick();
        RST = 1'b0; S_VALID = 1'b0;
        seg = 2;
        prog_sb.delete();
        data_sb.delete();
        chk("MRST_READY", S_READY, 1'b0);
        chk("MRST_DWE", DATA_WE, 1'b0);
        chk("MRST_DADDR", DATA_ADDR, 0);
        chk("MRST_DDATA", DATA_DATA, 0);
        chk("MRST_PWORDS", PROG_WORDS, 0);
        chk("MRST_DWORDS", DATA_WORDS, 0);
        chk("MRST_BUSY", BUSY, 1'b0);
        chk("MRST_RSTn", CORE_RSTn, 1'b0);
        boot_req();
        cyc(1'b1, 32'hF000_0000, 1'b1);
        cyc(1'b1, 32'hF100_0000, 1'b1);
        do_release();
        run(3, 1'b1);
        chk("RELOAD_CYCLES", CYCLES, 3);

        // program overflow: 1024 words with no S_LAST, the 1025th must be refused
        boot_req();
        for (int i = 0; i < 2**ADDR_W; i++) cyc(1'b1, 32'h5000_0000 + i, 1'b0);
        chk("OVF_ERR", ERR, 1'b1);
        chk("OVF_RSTn", CORE_RSTn, 1'b0);
        chk("OVF_BUSY", BUSY, 1'b0);
        chk("OVF_PWORDS", PROG_WORDS, 2**ADDR_W);
        cyc(1'b1, 32'h5000_0400, 1'b0);
        chk("OVF_PWORDS_HOLD", PROG_WORDS, 2**ADDR_W);
        chk("OVF_ERR_HOLD", ERR, 1'b1);

        // core never raises OK
        boot_req();
        chk("WD_ERR_CLR", ERR, 1'b0);
        cyc(1'b1, 32'h6000_0000, 1'b1);
        cyc(1'b1, 32'h6100_0000, 1'b1);
        do_release();
`ifdef RUN_WATCHDOG_EN
        run(WDOG_MAX, 1'b0);
        chk("WD_ERR", ERR, 1'b1);
        chk("WD_CYCLES", CYCLES, WDOG_MAX);
        chk("WD_EN", CORE_EN, 1'b0);
        chk("WD_RSTn", CORE_RSTn, 1'b0);
`else
        run(WDOG_MAX + 10, 1'b0);
        chk("NOWD_ERR", ERR, 1'b0);
        chk("NOWD_BUSY", BUSY, 1'b1);
        chk("NOWD_CYCLES", CYCLES, WDOG_MAX + 10);
        run(1, 1'b1);
        chk("NOWD_DONE", DONE, 1'b1);
        chk("NOWD_CYCLES_END", CYCLES, WDOG_MAX + 11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
